// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester (fetch / load-store) arbiter in front of a
// single-port memory. One transaction in flight at a time:
// IDLE -> BUSY_I/BUSY_D -> DONE -> IDLE.
// Optional build macro MEM_ARBITER_RR_EN turns fixed data-first priority into
// round-robin on simultaneous requests.
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_ack,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [DATA_W/8-1:0] d_be,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_ack,
  output logic                mem_req,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_ready,
  output logic                busy
);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, DONE} state_t;

  state_t state, state_next;
  logic   grant_i, grant_d;
  logic   prefer_d;
  logic   in_busy;

`ifdef MEM_ARBITER_RR_EN
  // 1 when the data port received the most recent grant
  logic last_d;

  // remember who was granted last; reset value "fetch" lets data win first
  always_ff @(posedge clk) begin
    if (!reset)       last_d <= 1'b0;
    else if (grant_d) last_d <= 1'b1;
    else if (grant_i) last_d <= 1'b0;
  end

  assign prefer_d = ~last_d;
`else
  assign prefer_d = 1'b1;
`endif

  assign in_busy = (state == BUSY_I) || (state == BUSY_D);
  assign busy    = (state != IDLE);

  // state register
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // next state and grant decision; arbitration happens only in IDLE
  always_comb begin
    state_next = state;
    grant_i    = 1'b0;
    grant_d    = 1'b0;
    case (state)
      IDLE: begin
        if (d_req && (prefer_d || !if_req)) begin
          grant_d    = 1'b1;
          state_next = BUSY_D;
        end else if (if_req) begin
          grant_i    = 1'b1;
          state_next = BUSY_I;
        end
      end
      BUSY_I, BUSY_D: if (mem_ready) state_next = DONE;
      DONE:           state_next = IDLE;
      default:        state_next = IDLE;
    endcase
  end

  // memory-side request registers, read data capture and one-cycle acks
  always_ff @(posedge clk) begin
    if (!reset) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_be    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      d_rdata   <= '0;
      if_ack    <= 1'b0;
      d_ack     <= 1'b0;
    end else begin
      if_ack <= 1'b0;
      d_ack  <= 1'b0;
      if (grant_d) begin
        mem_req   <= 1'b1;
        mem_we    <= d_we;
        mem_be    <= d_be;
        mem_addr  <= d_addr;
        mem_wdata <= d_wdata;
      end else if (grant_i) begin
        mem_req   <= 1'b1;
        mem_we    <= 1'b0;
        mem_be    <= '1;
        mem_addr  <= if_addr;
        mem_wdata <= '0;
      end
      // completion: fields stay put (only mem_req drops), ack lands in DONE
      if (in_busy && mem_ready) begin
        mem_req <= 1'b0;
        if (state == BUSY_I) begin
          if_rdata <= mem_rdata;
          if_ack   <= 1'b1;
        end else begin
          d_rdata <= mem_rdata;
          d_ack   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized rounds, checked
// against a transaction-level model (who should be served, in what order,
// with which fields and data, and after how many cycles).
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ack;
  logic        d_req, d_we;
  logic [3:0]  d_be;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        d_ack;
  logic        mem_req, mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ready;
  logic        busy;

  int checks = 0;
  int errors = 0;

  // model state
  bit          exp_last_d;
  logic [31:0] exp_if_rdata, exp_d_rdata;

  // current transaction fields
  logic [31:0] ti_addr, ti_rval, td_addr, td_wdata, td_rval;
  logic        td_we;
  logic [3:0]  td_be;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_rdata(d_rdata), .d_ack(d_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // arbitration rule on simultaneous requests
  function automatic bit model_prefers_d();
`ifdef MEM_ARBITER_RR_EN
    return !exp_last_d;
`else
    return 1'b1;
`endif
  endfunction

  task automatic model_reset();
    exp_last_d   = 1'b0;
    exp_if_rdata = '0;
    exp_d_rdata  = '0;
  endtask

  // One round starting #1 into an IDLE cycle: raise the chosen requests, act
  // as the memory with 'lat' wait cycles, check every grant/ack, optionally
  // drop the served request right after its grant.
  task automatic run_round(input bit ri, input bit rd, input int lat, input bit drop);
    bit cur_d, in_tx, left_i, left_d, ready_now;
    int wait_cnt, gap;
    if_req = ri; if_addr = ti_addr;
    d_req = rd; d_we = td_we; d_be = td_be; d_addr = td_addr; d_wdata = td_wdata;
    left_i = ri; left_d = rd;
    cur_d = rd && (!ri || model_prefers_d());
    in_tx = 0; ready_now = 0; wait_cnt = 0; gap = 0;
    for (int c = 0; c < 60 && (left_i || left_d); c++) begin
      @(negedge clk);
      gap++;
      if (ready_now) begin
        mem_ready = 0; ready_now = 0;
        chk("if_ack", if_ack, !cur_d);
        chk("d_ack", d_ack, cur_d);
        chk("mem_req_in_done", mem_req, 0);
        chk("busy_cycles", wait_cnt, lat + 1);
        if (cur_d) begin exp_d_rdata = td_rval;  left_d = 0; d_req = 0;  end
        else       begin exp_if_rdata = ti_rval; left_i = 0; if_req = 0; end
        chk("if_rdata", if_rdata, exp_if_rdata);
        chk("d_rdata", d_rdata, exp_d_rdata);
        in_tx = 0; gap = 0;
        cur_d = !cur_d;
      end else if (mem_req) begin
        if (!in_tx) begin
          in_tx = 1; wait_cnt = 0;
          chk("grant_latency", gap, 2);
          exp_last_d = cur_d;
        end
        chk("busy_hi", busy, 1);
        if (cur_d) chk("mem_fields_d", {mem_we, mem_be, mem_addr, mem_wdata},
                       {td_we, td_be, td_addr, td_wdata});
        else       chk("mem_fields_i", {mem_we, mem_be, mem_addr}, {1'b0, 4'hF, ti_addr});
        if (drop && wait_cnt == 0) begin
          if (cur_d) d_req = 0; else if_req = 0;
        end
        if (wait_cnt == lat) begin
          mem_ready = 1; mem_rdata = cur_d ? td_rval : ti_rval; ready_now = 1;
        end else mem_rdata = $urandom;
        wait_cnt++;
      end else begin
        chk("no_stray_ack", {if_ack, d_ack}, 2'b00);
        if (in_tx) chk("mem_req_held", mem_req, 1);
      end
    end
    chk("round_complete", {left_i, left_d}, 2'b00);
    @(negedge clk);
    chk("idle_after", {busy, mem_req, if_ack, d_ack}, 4'b0);
    chk("if_rdata_hold", if_rdata, exp_if_rdata);
    chk("d_rdata_hold", d_rdata, exp_d_rdata);
    @(posedge clk); #1;
  endtask

  task automatic rand_fields();
    ti_addr  = $urandom & 32'h7FFF_FFFC;
    td_addr  = $urandom | 32'h8000_0000;
    td_we    = 1'($urandom);
    td_be    = 4'($urandom);
    td_wdata = $urandom;
    ti_rval  = $urandom;
    td_rval  = $urandom;
  endtask

  initial begin
    bit cur_d, prev_mr;
    int na;
    // reset with memory noise present
    reset = 0; if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_be = 0;
    d_addr = 0; d_wdata = 0; mem_ready = 1; mem_rdata = 32'hA5A5_5A5A;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ctrl", {busy, mem_req, mem_we, if_ack, d_ack}, 5'b0);
    chk("reset_mem", {mem_be, mem_addr, mem_wdata}, '0);
    chk("reset_rdata", {if_rdata, d_rdata}, '0);
    @(posedge clk); #1;
    reset = 1; mem_ready = 0;
    @(posedge clk); #1;

    // lone fetch, immediate ready
    rand_fields(); ti_addr = 32'h10; ti_rval = 32'h0050_0093;
    run_round(1, 0, 0, 0);
    // lone store, ready after 3 wait cycles
    rand_fields(); td_addr = 32'h200; td_we = 1; td_be = 4'h3; td_wdata = 32'hDEAD_BEEF;
    run_round(0, 1, 3, 0);
    // simultaneous requests
    rand_fields();
    run_round(1, 1, 0, 0);

    // randomized rounds
    for (int r = 0; r < 30; r++) begin
      int pat;
      rand_fields();
      pat = $urandom_range(1, 3);
      run_round(pat[0], pat[1], $urandom_range(0, 3), ($urandom_range(0, 3) == 0));
    end

    // reset in the middle of a data transaction
    rand_fields();
    d_req = 1; d_we = td_we; d_be = td_be; d_addr = td_addr; d_wdata = td_wdata;
    @(negedge clk); @(negedge clk);
    chk("pre_reset_mem_req", mem_req, 1);
    @(posedge clk); #1;
    reset = 0; mem_ready = 1; mem_rdata = td_rval; d_req = 0;
    @(negedge clk); @(negedge clk);
    chk("midreset_state", {mem_req, busy, d_ack, if_ack}, 4'b0);
    chk("midreset_d_rdata", d_rdata, 32'h0);
    model_reset();
    @(posedge clk); #1;
    reset = 1; mem_ready = 0;
    @(negedge clk);
    chk("post_reset_quiet", {mem_req, busy, d_ack}, 3'b0);
    @(posedge clk); #1;

    // both requests held across four transactions
    rand_fields();
    if_req = 1; if_addr = ti_addr;
    d_req = 1; d_we = td_we; d_be = td_be; d_addr = td_addr; d_wdata = td_wdata;
    na = 0; prev_mr = 0; cur_d = 0;
    for (int c = 0; c < 80 && na < 4; c++) begin
      @(negedge clk);
      if (mem_req && !prev_mr) begin
        cur_d = model_prefers_d();
        chk("held_grant_order", (mem_addr === td_addr), cur_d);
        exp_last_d = cur_d;
      end
      if (if_ack || d_ack) begin
        na++;
        chk("held_ack", {if_ack, d_ack}, {!cur_d, cur_d});
        if (cur_d) exp_d_rdata = td_rval; else exp_if_rdata = ti_rval;
        chk("held_rdata", {if_rdata, d_rdata}, {exp_if_rdata, exp_d_rdata});
      end
      prev_mr = mem_req;
      mem_ready = mem_req;
      mem_rdata = (mem_addr === td_addr) ? td_rval : ti_rval;
    end
    if_req = 0; d_req = 0; mem_ready = 0;
    chk("held_ack_count", na, 4);
    @(negedge clk);
    chk("held_idle", {busy, mem_req, if_ack, d_ack}, 4'b0);
    @(posedge clk); #1;

    // fresh data request after the mid-transaction reset
    rand_fields();
    run_round(0, 1, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width for all address ports.
REQ-002 SHALL have parameter DATA_W, default 32, data width; byte-enable width is DATA_W/8.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port if_req  input  1  instruction-fetch read request, held until if_ack.
REQ-006 SHALL have port if_addr  input  ADDR_W  fetch address.
REQ-007 SHALL have ports if_rdata  output  DATA_W  (fetch read data) and if_ack  output  1  (fetch completion pulse).
REQ-008 SHALL have ports d_req, d_we (input, 1), d_be (input, DATA_W/8), d_addr (input, ADDR_W), d_wdata (input, DATA_W): the load/store request, held until d_ack.
REQ-009 SHALL have ports d_rdata  output  DATA_W  (load data) and d_ack  output  1  (load/store completion pulse).
REQ-010 SHALL have ports mem_req, mem_we (output, 1), mem_be (output, DATA_W/8), mem_addr (output, ADDR_W), mem_wdata (output, DATA_W): the single-port memory request.
REQ-011 SHALL have ports mem_rdata  input  DATA_W  and mem_ready  input  1  (memory completion, same cycle as valid mem_rdata).
REQ-012 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-013 SHALL implement the states IDLE, BUSY_I, BUSY_D and DONE.
REQ-014 IDLE, no request: SHALL stay in IDLE with mem_req=0.
REQ-015 IDLE, request present: SHALL grant one requester per priority rules and latch its addr, we, be and wdata into output registers.
- Fetch grant: we=0, be=all ones.
- Next state: BUSY_I or BUSY_D.
REQ-016 BUSY_x: mem_req=1 with latched fields held stable until the cycle mem_ready=1.
REQ-017 On that mem_ready cycle: SHALL register mem_rdata into x_rdata (BUSY_I -> if_rdata; BUSY_D -> d_rdata, stores included) and move to DONE.
REQ-018 DONE: SHALL assert exactly one of if_ack/d_ack for one cycle, with mem_req=0, then return to IDLE; no arbitration in DONE.
REQ-019 if_rdata and d_rdata SHALL hold their value until the next completion for the same requester.
REQ-020 Minimum latency, req in IDLE cycle N and mem_ready=1 in cycle N+1: mem_req in N+1, ack in N+2, IDLE in N+3.
REQ-021 Requesters SHALL deassert or change their request the cycle after ack; a request still high in IDLE is a new transaction.
REQ-022 A request dropped while its transaction is in BUSY_x or DONE SHALL NOT abort the transaction, and the ack SHALL still be issued.
REQ-023 Default priority with both requests in IDLE: d_req wins and if_req waits.

Reset
REQ-024 reset=0 at a rising edge SHALL force, from the next cycle:
- state=IDLE, busy=0
- mem_req=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0
- if_ack=0, d_ack=0, if_rdata=0, d_rdata=0
REQ-025 Reset asserted mid-transaction (BUSY_x or DONE) SHALL abandon the transaction with no ack issued; mem_ready during reset is ignored.

Configuration
REQ-026 With macro MEM_ARBITER_RR_EN defined: simultaneous requests SHALL be granted round-robin via a last-grant register.
- The requester not granted last wins.
- last-grant resets to "fetch", so data wins first.
- A lone request is always granted.
REQ-027 Without MEM_ARBITER_RR_EN: fixed priority per REQ-023, and no last-grant register exists.

Verification
REQ-028 Fetch alone, if_addr=0x10, mem_ready=1 immediately, mem_rdata=0x00500093 -> mem_req cycle N+1 with mem_addr=0x10 and mem_we=0; if_ack=1 and if_rdata=0x00500093 at N+2.
REQ-029 Store alone, d_addr=0x200, d_we=1, d_be=0x3, d_wdata=0xDEADBEEF, mem_ready delayed 3 cycles -> mem fields stable for 4 cycles; single d_ack; if_ack never asserted.
REQ-030 if_req and d_req both rising in the same IDLE cycle, macro undefined -> data served first, then fetch; two acks, data first.
REQ-031 Both requests held continuously for 4 transactions, MEM_ARBITER_RR_EN defined -> grant order D, I, D, I.
REQ-032 reset=0 driven during BUSY_D -> next cycle mem_req=0, busy=0, no d_ack; after release, fresh d_req completes normally.
